// File: rtl/uart_pkg.sv
// Shared definitions for the wb_uart Wishbone UART: register offsets, STATUS/CTRL
// bit positions, minimum divisor and the TX/RX state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    localparam int CTRL_RX_INT_EN = 16;
    localparam int CTRL_TX_INT_EN = 17;
    localparam int CTRL_LOOP      = 18;

    localparam logic [15:0] UART_MIN_DIV = 16'd16;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Divisors too small to centre-sample the start bit are raised to the floor.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < UART_MIN_DIV) ? UART_MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO feeding the UART transmitter; head word is visible
// combinationally on o_data whenever o_empty is low.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone classic slave 8N1 UART with TX FIFO, single-byte RX holding register
// and interrupt output. Define UART_LOOPBACK_EN to implement the CTRL loop bit.
module wb_uart
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 868,
    parameter int TX_DEPTH    = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        uart_int_o
);
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic [15:0] r_div;
    logic        r_rx_int_en;
    logic        r_tx_int_en;
    logic        r_int;
    logic        w_loop;

    logic        w_req, w_wr, w_rd;
    logic [1:0]  w_adr;
    logic        w_data_wr, w_data_rd, w_stat_rd, w_ctrl_wr;
    logic [15:0] w_div_merged;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = w_req & wb_we_i;
    assign w_rd      = w_req & ~wb_we_i;
    assign w_adr     = wb_adr_i[3:2];
    assign w_data_wr = w_wr & (w_adr == REG_DATA) & wb_sel_i[0];
    assign w_data_rd = w_rd & (w_adr == REG_DATA);
    assign w_stat_rd = w_rd & (w_adr == REG_STATUS);
    assign w_ctrl_wr = w_wr & (w_adr == REG_CTRL);
    assign w_div_merged = {wb_sel_i[1] ? wb_dat_i[15:8] : r_div[15:8],
                           wb_sel_i[0] ? wb_dat_i[7:0]  : r_div[7:0]};
    assign w_unused  = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:18], wb_sel_i[3]};

    // TX side
    tx_state_t   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        r_txd;
    logic        w_tx_tick, w_tx_pop, w_tx_full, w_fifo_empty, w_tx_empty;
    logic [7:0]  w_fifo_data;

    // RX side
    rx_state_t   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_div;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;
    logic [1:0]  r_rx_sync;
    logic        r_rx_prev;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_overrun, r_frame_err;
    logic        w_rx_pin, w_rx_in, w_rx_tick, w_rx_half_tick, w_rx_done, w_rx_ferr;

`ifdef UART_LOOPBACK_EN
    logic r_loop;
    assign w_loop     = r_loop;
    assign w_rx_pin   = r_loop ? r_txd : uart_rxd_i;
    assign uart_txd_o = r_loop ? 1'b1 : r_txd;
`else
    assign w_loop     = 1'b0;
    assign w_rx_pin   = uart_rxd_i;
    assign uart_txd_o = r_txd;
`endif

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat_o;
    assign uart_int_o = r_int;

    always_comb begin
        w_rd_data = '0;
        case (w_adr)
            REG_DATA:   w_rd_data = {24'b0, r_rx_data};
            REG_STATUS: begin
                w_rd_data[ST_RX_VALID]   = r_rx_valid;
                w_rd_data[ST_TX_FULL]    = w_tx_full;
                w_rd_data[ST_TX_EMPTY]   = w_tx_empty;
                w_rd_data[ST_RX_OVERRUN] = r_rx_overrun;
                w_rd_data[ST_FRAME_ERR]  = r_frame_err;
            end
            REG_CTRL: begin
                w_rd_data[15:0]           = r_div;
                w_rd_data[CTRL_RX_INT_EN] = r_rx_int_en;
                w_rd_data[CTRL_TX_INT_EN] = r_tx_int_en;
                w_rd_data[CTRL_LOOP]      = w_loop;
            end
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_rd ? w_rd_data : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_div       <= 16'(DEFAULT_DIV);
            r_rx_int_en <= 1'b0;
            r_tx_int_en <= 1'b0;
`ifdef UART_LOOPBACK_EN
            r_loop      <= 1'b0;
`endif
        end else if (w_ctrl_wr) begin
            if (wb_sel_i[0] | wb_sel_i[1]) begin
                r_div <= clamp_div(w_div_merged);
            end
            if (wb_sel_i[2]) begin
                r_rx_int_en <= wb_dat_i[CTRL_RX_INT_EN];
                r_tx_int_en <= wb_dat_i[CTRL_TX_INT_EN];
`ifdef UART_LOOPBACK_EN
                r_loop      <= wb_dat_i[CTRL_LOOP];
`endif
            end
        end
    end

    uart_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_data_wr),
        .i_data  (wb_dat_i[7:0]),
        .i_pop   (w_tx_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_tx_full),
        .o_empty (w_fifo_empty)
    );

    assign w_tx_tick  = (r_tx_cnt == r_tx_div - 16'd1);
    assign w_tx_empty = w_fifo_empty & (r_tx_state == TX_IDLE);
    // Popping coincides with every entry into TX_START, from idle or back-to-back.
    assign w_tx_pop   = ~w_fifo_empty &
                        ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_tick));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= UART_MIN_DIV;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_cnt <= w_tx_tick ? 16'd0 : r_tx_cnt + 16'd1;
            if (w_tx_pop) begin
                r_tx_state <= TX_START;
                r_tx_div   <= r_div;
                r_tx_shift <= w_fifo_data;
                r_tx_cnt   <= '0;
                r_txd      <= 1'b0;
            end else begin
                case (r_tx_state)
                    TX_IDLE: begin
                        r_tx_cnt <= '0;
                        r_txd    <= 1'b1;
                    end
                    TX_START: if (w_tx_tick) begin
                        r_tx_state <= TX_DATA;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end
                    TX_DATA: if (w_tx_tick) begin
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end
                    TX_STOP: if (w_tx_tick) begin
                        r_tx_state <= TX_IDLE;
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign w_rx_in        = r_rx_sync[1];
    assign w_rx_tick      = (r_rx_cnt == r_rx_div - 16'd1);
    assign w_rx_half_tick = (r_rx_cnt == {1'b0, r_rx_div[15:1]} - 16'd1);
    assign w_rx_done      = (r_rx_state == RX_STOP) & w_rx_tick & w_rx_in;
    assign w_rx_ferr      = (r_rx_state == RX_STOP) & w_rx_tick & ~w_rx_in;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= UART_MIN_DIV;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], w_rx_pin};
            r_rx_prev <= w_rx_in;
            r_rx_cnt  <= r_rx_cnt + 16'd1;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev & ~w_rx_in) begin
                        r_rx_state <= RX_START;
                        r_rx_div   <= r_div;
                    end
                end
                RX_START: if (w_rx_half_tick) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_state <= w_rx_in ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (w_rx_tick) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
                        r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: if (w_rx_tick) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle as a DATA read wins and is not an overrun.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
            r_int        <= 1'b0;
        end else begin
            if (w_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_stat_rd) begin
                r_rx_overrun <= 1'b0;
                r_frame_err  <= 1'b0;
            end
            if (w_rx_done & r_rx_valid & ~w_data_rd) begin
                r_rx_overrun <= 1'b1;
            end
            if (w_rx_ferr) begin
                r_frame_err <= 1'b1;
            end
            r_int <= (r_rx_int_en & r_rx_valid) | (r_tx_int_en & w_tx_empty);
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Scoreboard bench for wb_uart: bus reads and serial TX frames are checked by
// monitors against expectations queued when the stimulus is issued.
module tb_wb_uart;
    localparam int TB_DIV = 16;
    localparam logic [31:0] A_DATA = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_CTRL = 32'h3000_0008;
    localparam logic [31:0] A_RSVD = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic        uart_rxd_i, uart_txd_o, uart_int_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];
    logic        tx_mon_en;
    logic        txd_at_ack, int_at_ack;

    always #5 clk = ~clk;

    wb_uart #(.DEFAULT_DIV(868), .TX_DEPTH(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .uart_rxd_i (uart_rxd_i),
        .uart_txd_o (uart_txd_o),
        .uart_int_o (uart_int_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        int n;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wb_ack_o !== 1'b1 && n < 16);
        if (wb_ack_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_timeout adr=%h actual=no_ack required=ack", adr);
        end
        txd_at_ack = uart_txd_o;
        int_at_ack = uart_int_o;
        if (we) $display("WR adr=%h dat=%h sel=%b", adr, dat, sel);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        check("ack_single_cycle", {31'b0, wb_ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus(1'b1, adr, dat, sel);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        bus(1'b0, adr, 32'd0, 4'hF);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd_i = bits[i];
            repeat (TB_DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd_i = 1'b1;
        repeat (20) @(negedge clk);
        $display("RXDRV byte=%h stop=%b", b, stop);
    endtask

    // Bus read monitor
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (wb_ack_o === 1'b1 && wb_we_i === 1'b0) begin
                if (rd_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual=%h required=none", wb_dat_o);
                end else begin
                    e  = rd_exp_q.pop_front();
                    nm = rd_name_q.pop_front();
                    $display("RD adr=%h dat=%h exp=%h (%s)", wb_adr_i, wb_dat_o, e, nm);
                    check(nm, wb_dat_o, e);
                end
            end
        end
    end

    // Serial TX monitor: every one of the 160 clocks of a frame is compared.
    initial begin
        logic [7:0] e;
        logic [9:0] bits;
        int         mism;
        forever begin
            @(negedge clk);
            if (tx_mon_en === 1'b1 && uart_txd_o === 1'b0) begin
                if (tx_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_frame actual=frame required=idle");
                    repeat (10 * TB_DIV - 1) @(negedge clk);
                end else begin
                    e    = tx_exp_q.pop_front();
                    bits = {1'b1, e, 1'b0};
                    for (int b = 0; b < 10; b++) begin
                        mism = 0;
                        for (int s = 0; s < TB_DIV; s++) begin
                            if (b != 0 || s != 0) @(negedge clk);
                            if (uart_txd_o !== bits[b]) mism++;
                        end
                        check($sformatf("tx_%h_bit%0d_bad_clocks", e, b), mism, 32'd0);
                    end
                    $display("TX frame byte=%h", e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; tx_mon_en = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        uart_rxd_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'b0, uart_txd_o}, 32'd1);
        check("rst_int", {31'b0, uart_int_o}, 32'd0);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst = 1'b0;

        // Reset defaults and CTRL behaviour
        rd(A_CTRL, 32'h0000_0364, "rst_ctrl");
        rd(A_STAT, 32'h0000_0004, "rst_status");
        wr(A_CTRL, 32'h0000_0005, 4'b0011);
        rd(A_CTRL, 32'h0000_0010, "ctrl_div_clamp");
        wr(A_CTRL, 32'h0000_FF20, 4'b0001);
        rd(A_CTRL, 32'h0000_0020, "ctrl_byte_lane");
        wr(A_CTRL, 32'h0000_0010, 4'b0011);
        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        rd(A_RSVD, 32'h0000_0000, "rsvd_reads_zero");

        // Single TX frame; DATA write without sel[0] must not push
        wr(A_DATA, 32'h0000_0077, 4'b1110);
        tx_exp_q.push_back(8'hA5);
        wr(A_DATA, 32'h0000_00A5, 4'b0001);
        check("tx_idle_at_ack", {31'b0, txd_at_ack}, 32'd1);
        check("tx_start_latency", {31'b0, uart_txd_o}, 32'd0);
        repeat (10 * TB_DIV + 10) @(negedge clk);
        rd(A_STAT, 32'h0000_0004, "tx_done_status");

        // FIFO overflow
        for (int i = 1; i <= 5; i++) begin
            tx_exp_q.push_back(8'(i));
            wr(A_DATA, 32'(i), 4'b0001);
        end
        rd(A_STAT, 32'h0000_0002, "fifo_full_status");
        wr(A_DATA, 32'h0000_0006, 4'b0001);
        repeat (5 * 10 * TB_DIV + 40) @(negedge clk);
        rd(A_STAT, 32'h0000_0004, "overflow_drained");

        // RX with interrupt
        wr(A_CTRL, 32'h0001_0010, 4'b0111);
        check("int_before_rx", {31'b0, uart_int_o}, 32'd0);
        send_rx(8'h3C, 1'b1);
        check("int_after_rx", {31'b0, uart_int_o}, 32'd1);
        rd(A_DATA, 32'h0000_003C, "rx_data_3c");
        check("int_at_read_ack", {31'b0, int_at_ack}, 32'd1);
        check("int_fall_after_read", {31'b0, uart_int_o}, 32'd0);

        // RX overrun and framing error
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(A_STAT, 32'h0000_000D, "overrun_status");
        rd(A_DATA, 32'h0000_0022, "overrun_data");
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b0);
        rd(A_STAT, 32'h0000_0015, "frame_err_status");
        rd(A_STAT, 32'h0000_0005, "sticky_cleared");
        rd(A_DATA, 32'h0000_0044, "frame_err_kept_data");
        rd(A_STAT, 32'h0000_0004, "rx_valid_cleared");

        // TX-empty interrupt
        wr(A_CTRL, 32'h0002_0010, 4'b0111);
        repeat (2) @(negedge clk);
        check("tx_int", {31'b0, uart_int_o}, 32'd1);

        // Loop bit
        wr(A_CTRL, 32'h0004_0010, 4'b0111);
`ifdef UART_LOOPBACK_EN
        rd(A_CTRL, 32'h0004_0010, "ctrl_loop_bit");
        wr(A_DATA, 32'h0000_005A, 4'b0001);
        bad = 0;
        repeat (12 * TB_DIV) begin
            @(negedge clk);
            if (uart_txd_o !== 1'b1) bad++;
        end
        check("loop_txd_held_high", bad, 32'd0);
        rd(A_DATA, 32'h0000_005A, "loop_rx_data");
`else
        rd(A_CTRL, 32'h0000_0010, "ctrl_loop_ignored");
`endif
        wr(A_CTRL, 32'h0000_0010, 4'b0111);

        // Reset mid-frame
        tx_mon_en = 1'b0;
        wr(A_DATA, 32'h0000_0000, 4'b0001);
        repeat (40) @(negedge clk);
        check("txd_low_mid_frame", {31'b0, uart_txd_o}, 32'd0);
        #2 rst = 1'b1;
        #1 check("txd_async_reset", {31'b0, uart_txd_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(A_CTRL, 32'h0000_0364, "ctrl_after_reset");
        rd(A_STAT, 32'h0000_0004, "status_after_reset");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_txd_o !== 1'b1) bad++;
        end
        check("partial_frame_lost", bad, 32'd0);

        check("tx_queue_drained", tx_exp_q.size(), 32'd0);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
